// File: rtl/sram_addr_gen_if.sv
// Signal bundle between the AVR serial address port / SNES bus and the SRAM address generator.
// The master side drives the AVR and SNES inputs; the slave side is the generator itself.
interface sram_addr_gen_if #(
    parameter int ADDR_W = 21,
    parameter int CNT_W  = 5
) ();
    logic              avr_sreg_en_n;
    logic              avr_sclk;
    logic              avr_si;
    logic              avr_counter_n;
    logic              avr_snes_mode;
    logic [ADDR_W-1:0] snes_addr;
    logic [ADDR_W-1:0] sram_addr;
    logic [CNT_W-1:0]  bit_cnt;
    logic              addr_ovf;
    logic [1:0]        state;

    modport master (
        output avr_sreg_en_n, avr_sclk, avr_si, avr_counter_n, avr_snes_mode, snes_addr,
        input  sram_addr, bit_cnt, addr_ovf, state
    );

    modport slave (
        input  avr_sreg_en_n, avr_sclk, avr_si, avr_counter_n, avr_snes_mode, snes_addr,
        output sram_addr, bit_cnt, addr_ovf, state
    );
endinterface

// File: rtl/sram_addr_gen.sv
// SRAM address generator: serial MSB-first address load from the AVR, AVR-driven increment,
// and a SNES pass-through mode. All AVR inputs are asynchronous and synchronized here.
module sram_addr_gen #(
    parameter int ADDR_W = 21,
    parameter int CNT_W  = 5
) (
    input  logic          avr_clk,
    input  logic          avr_reset_n,
    sram_addr_gen_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        SNES  = 2'b10
    } state_t;

    // Synchronizer lanes: {snes_mode, counter_n, si, sclk, sreg_en_n}; the active-low strobes idle high.
    localparam logic [4:0] SYNC_RST = 5'b01001;

    logic              rst_meta;
    logic              rst_n_sync;
    logic [4:0]        in_p0;
    logic [4:0]        in_p1;
    logic [2:0]        hist_p2;
    logic [ADDR_W-1:0] shreg;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] sram_addr_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic              addr_ovf_r;
    state_t            state_r;

    logic sreg_en_n_s;
    logic si_s;
    logic snes_mode_s;
    logic sreg_en_rise;
    logic sclk_rise;
    logic cnt_fall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_W'(ADDR_W)) ? c : c + CNT_W'(1);
    endfunction

    // Reset asserts asynchronously but releases on an avr_clk edge.
    always_ff @(posedge avr_clk or negedge avr_reset_n) begin
        if (!avr_reset_n) begin
            rst_meta   <= 1'b0;
            rst_n_sync <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_n_sync <= rst_meta;
        end
    end

    // p0/p1: two-flop synchronizer, p2: history for edge detection.
    always_ff @(posedge avr_clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            in_p0   <= SYNC_RST;
            in_p1   <= SYNC_RST;
            hist_p2 <= {SYNC_RST[3], SYNC_RST[1], SYNC_RST[0]};
        end else begin
            in_p0   <= {bus.avr_snes_mode, bus.avr_counter_n, bus.avr_si,
                        bus.avr_sclk, bus.avr_sreg_en_n};
            in_p1   <= in_p0;
            hist_p2 <= {in_p1[3], in_p1[1], in_p1[0]};
        end
    end

    assign sreg_en_n_s  = in_p1[0];
    assign si_s         = in_p1[2];
    assign snes_mode_s  = in_p1[4];
    assign sreg_en_rise = in_p1[0] & ~hist_p2[0];
    assign sclk_rise    = in_p1[1] & ~hist_p2[1];
    assign cnt_fall     = ~in_p1[3] & hist_p2[2];

    always_ff @(posedge avr_clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_r     <= IDLE;
            shreg       <= '0;
            addr_cnt    <= '0;
            sram_addr_r <= '0;
            bit_cnt_r   <= '0;
            addr_ovf_r  <= 1'b0;
        end else begin
            sram_addr_r <= (state_r == SNES) ? bus.snes_addr : addr_cnt;
            if (snes_mode_s) begin
                state_r <= SNES;
            end else begin
                unique case (state_r)
                    IDLE: begin
                        if (!sreg_en_n_s) begin
                            state_r    <= SHIFT;
                            bit_cnt_r  <= '0;
                            addr_ovf_r <= 1'b0;
                        end else if (cnt_fall) begin
                            addr_cnt <= addr_cnt + ADDR_W'(1);
                        end
                    end
                    SHIFT: begin
                        // Counter edges are ignored here, so a load always beats a coincident increment.
                        if (sreg_en_rise) begin
                            addr_cnt <= shreg;
                            state_r  <= IDLE;
                        end else if (sclk_rise) begin
                            shreg     <= {shreg[ADDR_W-2:0], si_s};
                            bit_cnt_r <= sat_inc(bit_cnt_r);
                            if (bit_cnt_r == CNT_W'(ADDR_W)) begin
                                addr_ovf_r <= 1'b1;
                            end
                        end
                    end
                    SNES:    state_r <= IDLE;
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

    assign bus.sram_addr = sram_addr_r;
    assign bus.bit_cnt   = bit_cnt_r;
    assign bus.addr_ovf  = addr_ovf_r;
    assign bus.state     = state_r;
endmodule

// File: tb/tb_sram_addr_gen.sv
// Scoreboard bench for sram_addr_gen: directed AVR serial loads, increments, SNES mode and reset.
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_sram_addr_gen;
    localparam int ADDR_W = 21;
    localparam int CNT_W  = 5;

    typedef struct {
        string             name;
        logic [ADDR_W-1:0] addr;
        logic [CNT_W-1:0]  cnt;
        logic              ovf;
        logic [1:0]        st;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic sample = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    sram_addr_gen_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    sram_addr_gen #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .avr_clk     (clk),
        .avr_reset_n (rst_n),
        .bus         (bus)
    );

    always @(negedge clk) begin
        exp_t e;
        if (sample) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_underflow: sample requested with no expectation queued");
            end else begin
                e = exp_q.pop_front();
                if (bus.sram_addr !== e.addr || bus.bit_cnt !== e.cnt ||
                    bus.addr_ovf !== e.ovf || bus.state !== e.st) begin
                    failures++;
                    $display("FAIL %s: got sram_addr=%h bit_cnt=%0d addr_ovf=%0b state=%0d, expected sram_addr=%h bit_cnt=%0d addr_ovf=%0b state=%0d",
                             e.name, bus.sram_addr, bus.bit_cnt, bus.addr_ovf, bus.state,
                             e.addr, e.cnt, e.ovf, e.st);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [ADDR_W-1:0] a,
                              input logic [CNT_W-1:0] c, input logic o, input logic [1:0] s);
        exp_t e;
        e.name = name;
        e.addr = a;
        e.cnt  = c;
        e.ovf  = o;
        e.st   = s;
        exp_q.push_back(e);
        sample = 1'b1;
        @(negedge clk);
        #1;
        sample = 1'b0;
    endtask

    task automatic enter_shift();
        bus.avr_sreg_en_n = 1'b0;
        cyc(4);
    endtask

    task automatic shift_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.avr_si = v[i];
            cyc(3);
            bus.avr_sclk = 1'b1;
            cyc(3);
            bus.avr_sclk = 1'b0;
        end
    endtask

    task automatic load(input logic [63:0] v, input int n);
        enter_shift();
        shift_bits(v, n);
        cyc(2);
        bus.avr_sreg_en_n = 1'b1;
        cyc(5);
    endtask

    task automatic pulse_cnt();
        bus.avr_counter_n = 1'b0;
        cyc(4);
        bus.avr_counter_n = 1'b1;
        cyc(4);
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.avr_sreg_en_n = 1'b1;
        bus.avr_sclk      = 1'b0;
        bus.avr_si        = 1'b0;
        bus.avr_counter_n = 1'b1;
        bus.avr_snes_mode = 1'b0;
        bus.snes_addr     = '0;
        cyc(3);
        expect_out("reset_state", 21'h000000, 5'd0, 1'b0, 2'b00);
        rst_n = 1'b1;
        cyc(5);
        expect_out("post_release_quiet", 21'h000000, 5'd0, 1'b0, 2'b00);

        load(64'h04CCF, 21);
        expect_out("load_04ccf", 21'h004CCF, 5'd21, 1'b0, 2'b00);
        pulse_cnt();
        expect_out("incr_04cd0", 21'h004CD0, 5'd21, 1'b0, 2'b00);

        load(64'h1FFFFF, 21);
        expect_out("load_all_ones", 21'h1FFFFF, 5'd21, 1'b0, 2'b00);
        pulse_cnt();
        expect_out("wrap_to_zero", 21'h000000, 5'd21, 1'b0, 2'b00);
        pulse_cnt();
        expect_out("after_wrap_one", 21'h000001, 5'd21, 1'b0, 2'b00);

        load(64'h60ABCD, 23);
        expect_out("overflow_load", 21'h00ABCD, 5'd21, 1'b1, 2'b00);
        load(64'h5, 3);
        expect_out("short_load", 21'h055E6D, 5'd3, 1'b0, 2'b00);

        load(64'h000100, 21);
        expect_out("load_0100", 21'h000100, 5'd21, 1'b0, 2'b00);
        bus.snes_addr     = 21'h1A2B3C;
        bus.avr_snes_mode = 1'b1;
        cyc(4);
        expect_out("snes_follow", 21'h1A2B3C, 5'd21, 1'b0, 2'b10);
        bus.snes_addr = 21'h012345;
        cyc(2);
        expect_out("snes_track", 21'h012345, 5'd21, 1'b0, 2'b10);
        pulse_cnt();
        expect_out("snes_cnt_ignored", 21'h012345, 5'd21, 1'b0, 2'b10);
        bus.avr_snes_mode = 1'b0;
        cyc(4);
        expect_out("snes_exit", 21'h000100, 5'd21, 1'b0, 2'b00);
        pulse_cnt();
        expect_out("incr_after_snes", 21'h000101, 5'd21, 1'b0, 2'b00);

        enter_shift();
        shift_bits(64'h3FF, 10);
        rst_n = 1'b0;
        #1;
        bus.avr_sreg_en_n = 1'b1;
        expect_out("reset_mid_shift", 21'h000000, 5'd0, 1'b0, 2'b00);
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        expect_out("post_reset_release", 21'h000000, 5'd0, 1'b0, 2'b00);
        load(64'h000042, 21);
        expect_out("reload_0042", 21'h000042, 5'd21, 1'b0, 2'b00);

        enter_shift();
        shift_bits(64'h0F0F0, 21);
        cyc(2);
        bus.avr_sreg_en_n = 1'b1;
        bus.avr_counter_n = 1'b0;
        cyc(5);
        bus.avr_counter_n = 1'b1;
        cyc(4);
        expect_out("load_beats_incr", 21'h00F0F0, 5'd21, 1'b0, 2'b00);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_addr_gen.md
SRAM_ADDR_GEN -- requirements
Module: sram_addr_gen

Interface
REQ-001 Parameter ADDR_W, default 21: SRAM address width in bits.
REQ-002 Parameter CNT_W, default 5: width of the shift bit counter; SHALL satisfy 2^CNT_W > ADDR_W.
REQ-003 avr_clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 avr_reset_n  in  1  asynchronous, active-low reset.
REQ-005 avr_sreg_en_n  in  1  low enables serial address load (async to avr_clk).
REQ-006 avr_sclk  in  1  serial shift clock from the AVR; a rising edge shifts one bit (async).
REQ-007 avr_si  in  1  serial address data, MSB first (async).
REQ-008 avr_counter_n  in  1  falling edge requests an address increment (async).
REQ-009 avr_snes_mode  in  1  high selects the SNES address path (async).
REQ-010 snes_addr  in  ADDR_W  SNES bus address.
REQ-011 sram_addr  out  ADDR_W  registered SRAM address to the bus FSM and SRAM.
REQ-012 bit_cnt  out  CNT_W  bits shifted in the current load, saturating at ADDR_W.
REQ-013 addr_ovf  out  1  more than ADDR_W bits shifted in the current load.
REQ-014 state  out  2  FSM state: IDLE=00, SHIFT=01, SNES=10.

Function
REQ-015 avr_sreg_en_n, avr_sclk, avr_si, avr_counter_n and avr_snes_mode SHALL each pass a 2-flop synchronizer; edge detection SHALL compare the 2nd flop with a 3rd history flop.
REQ-016 Latency: an input level first captured at rising edge N SHALL take effect at edge N+2 and be visible on outputs after N+2.
REQ-017 Registers: shreg (ADDR_W), addr_cnt (ADDR_W), bit_cnt, addr_ovf, state.
REQ-018 IDLE -> SHIFT when synced sreg_en_n is low and synced snes_mode is low; on entry, bit_cnt and addr_ovf SHALL clear.
REQ-019 In SHIFT, each synced avr_sclk rising edge: shreg <= {shreg[ADDR_W-2:0], si}; bit_cnt increments, saturating at ADDR_W; a shift with bit_cnt already at ADDR_W SHALL set addr_ovf (the oldest bit is discarded).
REQ-020 SHIFT -> IDLE on synced sreg_en_n rising edge; in that same cycle, addr_cnt <= shreg, so the last ADDR_W shifted bits are loaded.
REQ-021 A load with fewer than ADDR_W bits SHALL load shreg as-is; the upper bits are whatever shreg held before.
REQ-022 In IDLE, a synced avr_counter_n falling edge SHALL do addr_cnt <= addr_cnt + 1 modulo 2^ADDR_W, so all-ones wraps to 0.
REQ-023 avr_counter_n edges in SHIFT or SNES SHALL be ignored and not queued.
REQ-024 If the load of REQ-020 and a counter edge occur in the same cycle, the load wins and the increment is dropped.
REQ-025 Any state -> SNES when synced snes_mode is high; this overrides SHIFT, discards the partial load and leaves addr_cnt unchanged.
REQ-026 SNES -> IDLE when synced snes_mode is low, even if sreg_en_n is low; SHIFT needs a fresh low level evaluated from IDLE on the next cycle.
REQ-027 sram_addr SHALL be registered: snes_addr in SNES, addr_cnt otherwise; it updates on the clock edge after the state/addr_cnt change.
REQ-028 avr_sclk edges outside SHIFT SHALL be ignored.

Reset
REQ-029 While avr_reset_n is low, the block SHALL immediately (asynchronously) set: sram_addr=0, addr_cnt=0, shreg=0, bit_cnt=0, addr_ovf=0, state=IDLE, all synchronizer and history flops=0 except the avr_sreg_en_n and avr_counter_n chains, which SHALL be set to 1.
REQ-030 Reset deassertion SHALL be synchronized to avr_clk, with release on a rising edge; no spurious edge SHALL be detected in the first cycles after release.
REQ-031 Reset asserted mid-SHIFT SHALL abandon the load, with no transfer to addr_cnt.

Verification
REQ-032 Shift 21 bits encoding 0x04CCF MSB first, then deassert sreg_en_n -> sram_addr=0x04CCF, bit_cnt=21, addr_ovf=0, state=IDLE.
REQ-033 With addr_cnt=0x1FFFFF, pulse avr_counter_n low then high -> sram_addr=0x000000 exactly once; a second pulse -> 0x000001.
REQ-034 Shift 23 bits (0b11 then 21-bit 0x0ABCD) -> addr_ovf=1, bit_cnt=21, sram_addr=0x0ABCD after load.
REQ-035 Set addr_cnt=0x000100, raise snes_mode with snes_addr=0x1A2B3C (21-bit 0x1A2B3C&0x1FFFFF) -> sram_addr follows snes_addr; counter pulses are ignored; drop snes_mode -> sram_addr=0x000100.
REQ-036 Assert avr_reset_n low after 10 of 21 bits -> all outputs 0 and state=IDLE immediately; after release, a full reload of 0x000042 -> sram_addr=0x000042.
REQ-037 Drive the sreg_en_n rising edge and a counter_n falling edge in the same clock -> sram_addr equals the loaded value, not value+1.
